// File: rtl/vram_responder.sv
// vram_responder: Wishbone B3 classic slave fronting the on-chip video RAM,
// with programmable wait states, byte-lane writes and out-of-range error termination.
module vram_responder #(
  parameter int AW          = 13,
  parameter int DW          = 16,
  parameter int DEPTH       = 4096,
  parameter int WAIT_STATES = 1
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            cyc_i,
  input  logic            stb_i,
  input  logic            we_i,
  input  logic [AW-1:0]   adr_i,
  input  logic [DW-1:0]   dat_i,
  input  logic [DW/8-1:0] sel_i,
  output logic [DW-1:0]   dat_o,
  output logic            ack_o,
  output logic            err_o
);
  localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] LIMIT = (AW+1)'(DEPTH);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state, state_nx;
  logic [3:0] cnt;
  logic [AW-1:0] adr_q;
  logic we_q;
  logic [DW-1:0] dat_q;
  logic [DW/8-1:0] sel_q;
  logic [DW-1:0] ram [DEPTH];
  logic req, go, in_range;
  logic [IW-1:0] idx;
  assign req = cyc_i & stb_i;
  assign in_range = {1'b0, adr_q} < LIMIT;
  assign idx = adr_q[IW-1:0];
  always_comb begin
    state_nx = state == IDLE ? (req ? WAIT : IDLE)
             : state == WAIT ? (!req ? IDLE : cnt == 4'd0 ? RESP : WAIT)
             : IDLE;
    go = state == WAIT && req && cnt == 4'd0;
  end
  always_ff @(posedge clk_i or negedge reset_i)
    if (!reset_i) begin
      state <= IDLE;
      cnt   <= 4'd0;
      ack_o <= 1'b0;
      err_o <= 1'b0;
      dat_o <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && req) cnt <= 4'(WAIT_STATES);
      else if (state == WAIT && cnt != 4'd0) cnt <= cnt - 4'd1;
      ack_o <= go & in_range;
      err_o <= go & ~in_range;
      if (go && !we_q) dat_o <= in_range ? ram[idx] : '0;
    end
  // The transfer is frozen at the request edge; later bus changes only matter for abort.
  always_ff @(posedge clk_i)
    if (state == IDLE && req) begin
      adr_q <= adr_i;
      we_q  <= we_i;
      dat_q <= dat_i;
      sel_q <= sel_i;
    end
  always_ff @(posedge clk_i)
    for (int k = 0; k < DW/8; k++)
      if (go && we_q && in_range && sel_q[k]) ram[idx][8*k +: 8] <= dat_q[8*k +: 8];
endmodule

// File: tb/tb_vram_responder.sv
// tb_vram_responder: randomized bus transfers on three responders (WAIT_STATES 1, 3, 0),
// checked against a word-array memory model and the documented latency rules.
module tb_vram_responder;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic        rst_n [3];
  logic        cyc [3], stb [3], we [3], ack [3], err [3];
  logic [12:0] adr [3];
  logic [15:0] dat [3], dato [3];
  logic [1:0]  sel [3];
  for (genvar g = 0; g < 3; g++) begin : g_dut
    vram_responder #(.WAIT_STATES(g == 0 ? 1 : g == 1 ? 3 : 0)) u_dut (
      .clk_i(clk), .reset_i(rst_n[g]), .cyc_i(cyc[g]), .stb_i(stb[g]), .we_i(we[g]),
      .adr_i(adr[g]), .dat_i(dat[g]), .sel_i(sel[g]), .dat_o(dato[g]), .ack_o(ack[g]), .err_o(err[g])
    );
  end
  logic [15:0] mem [3][4096];
  bit          vld [3][4096];
  int n_chk = 0, n_fail = 0;
  function automatic int ws(input int d);
    return d == 0 ? 1 : d == 1 ? 3 : 0;
  endfunction
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic xfer(input int d, input logic w, input logic [12:0] a, input logic [15:0] wd, input logic [1:0] s);
    int lat = 0;
    bit hit = 0;
    bit ok = a < 13'd4096;
    @(negedge clk);
    cyc[d] = 1; stb[d] = 1; we[d] = w; adr[d] = a; dat[d] = wd; sel[d] = s;
    while (!hit && lat < 20) begin
      @(negedge clk);
      lat++;
      hit = ack[d] | err[d];
      if (!hit) begin
        adr[d] = 13'($urandom); dat[d] = 16'($urandom); we[d] = 1'($urandom); sel[d] = 2'($urandom);
      end
    end
    check($sformatf("lat d%0d a%h", d, a), 32'(lat), 32'(ws(d) + 2));
    check($sformatf("ack d%0d a%h", d, a), 32'(ack[d]), 32'(ok));
    check($sformatf("err d%0d a%h", d, a), 32'(err[d]), 32'(!ok));
    if (!w && !ok) check($sformatf("rdat_oor d%0d a%h", d, a), 32'(dato[d]), 32'd0);
    if (!w && ok && vld[d][a[11:0]]) check($sformatf("rdat d%0d a%h", d, a), 32'(dato[d]), 32'(mem[d][a[11:0]]));
    if (w && ok) begin
      for (int k = 0; k < 2; k++) if (s[k]) mem[d][a[11:0]][8*k +: 8] = wd[8*k +: 8];
      vld[d][a[11:0]] = vld[d][a[11:0]] | (s == 2'b11);
    end
    cyc[d] = 0; stb[d] = 0;
    @(negedge clk);
    check($sformatf("pulse d%0d", d), 32'({ack[d], err[d]}), 32'd0);
  endtask
  task automatic abort(input int d, input logic [12:0] a, input logic [15:0] wd);
    @(negedge clk);
    cyc[d] = 1; stb[d] = 1; we[d] = 1; adr[d] = a; dat[d] = wd; sel[d] = 2'b11;
    @(negedge clk);
    stb[d] = 0;
    for (int i = 0; i < ws(d) + 4; i++) begin
      @(negedge clk);
      check($sformatf("abort d%0d", d), 32'({ack[d], err[d]}), 32'd0);
    end
    cyc[d] = 0;
  endtask
  task automatic b2b(input int d, input logic [12:0] a0);
    int t;
    bit hit;
    @(negedge clk);
    cyc[d] = 1; stb[d] = 1; we[d] = 0; adr[d] = a0;
    for (int j = 0; j < 3; j++) begin
      t = 0; hit = 0;
      while (!hit && t < 20) begin
        @(negedge clk);
        t++;
        hit = ack[d];
      end
      check($sformatf("b2b_gap d%0d j%0d", d, j), 32'(t), 32'(ws(d) + (j == 0 ? 2 : 3)));
      check($sformatf("b2b_dat d%0d j%0d", d, j), 32'(dato[d]), 32'(mem[d][a0 + 12'(j)]));
      if (j < 2) adr[d] = a0 + 13'(j + 1);
      else begin cyc[d] = 0; stb[d] = 0; end
    end
    @(negedge clk);
  endtask
  task automatic rst_mid(input int d, input logic [12:0] a, input logic [15:0] wd);
    xfer(d, 0, 13'h010, 16'h0, 2'b00);
    @(negedge clk);
    cyc[d] = 1; stb[d] = 1; we[d] = 1; adr[d] = a; dat[d] = wd; sel[d] = 2'b11;
    @(negedge clk);
    #2 rst_n[d] = 0;
    #1;
    check($sformatf("rst_ack d%0d", d), 32'(ack[d]), 32'd0);
    check($sformatf("rst_err d%0d", d), 32'(err[d]), 32'd0);
    check($sformatf("rst_dat d%0d", d), 32'(dato[d]), 32'd0);
    cyc[d] = 0; stb[d] = 0;
    @(negedge clk);
    rst_n[d] = 1;
    xfer(d, 0, a, 16'h0, 2'b00);
  endtask
  initial begin
    logic [12:0] a;
    int r;
    for (int d = 0; d < 3; d++) begin
      rst_n[d] = 0; cyc[d] = 0; stb[d] = 0; we[d] = 0; adr[d] = '0; dat[d] = '0; sel[d] = '0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check($sformatf("reset_ack d%0d", d), 32'(ack[d]), 32'd0);
      check($sformatf("reset_err d%0d", d), 32'(err[d]), 32'd0);
      check($sformatf("reset_dat d%0d", d), 32'(dato[d]), 32'd0);
      rst_n[d] = 1;
    end
    for (int d = 0; d < 3; d++) begin
      xfer(d, 1, 13'h010, 16'hBEEF, 2'b11);
      xfer(d, 0, 13'h010, 16'h0, 2'b00);
      xfer(d, 1, 13'h005, 16'h1234, 2'b11);
      xfer(d, 1, 13'h005, 16'hAB00, 2'b10);
      xfer(d, 0, 13'h005, 16'h0, 2'b00);
      for (int i = 0; i < 32; i++) if (i != 16 && i != 5) xfer(d, 1, 13'(i), 16'($urandom), 2'b11);
      xfer(d, 1, 13'hFFF, 16'($urandom), 2'b11);
      xfer(d, 0, 13'h1000, 16'h0, 2'b00);
      xfer(d, 1, 13'h1FFF, 16'hDEAD, 2'b11);
      xfer(d, 0, 13'hFFF, 16'h0, 2'b00);
      xfer(d, 1, 13'h003, 16'hFFFF, 2'b00);
      xfer(d, 0, 13'h003, 16'h0, 2'b00);
      xfer(d, 1, 13'h007, 16'h0000, 2'b11);
      abort(d, 13'h007, 16'h5555);
      xfer(d, 0, 13'h007, 16'h0, 2'b00);
      b2b(d, 13'h001);
      for (int i = 0; i < 60; i++) begin
        r = $urandom_range(0, 9);
        a = r < 7 ? 13'($urandom_range(0, 31)) : r < 8 ? 13'hFFF : 13'h1000 | 13'($urandom_range(0, 4095));
        xfer(d, 1'($urandom), a, 16'($urandom), 2'($urandom));
      end
      rst_mid(d, 13'h007, 16'h5A5A);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/vram_responder.md
Name: vram_responder

Overview:
- Wishbone B3 classic slave that serves the CGIA fetcher's master bus cycles (and CPU-side accesses) out of an on-chip video RAM.
- Accepts single read/write transfers, inserts a programmable number of wait states and acknowledges each transfer with a one-cycle ack_o.
- Flags out-of-range addresses with err_o.
- Sits between the bus interconnect and the video memory array; it is the responder end of the bus the fetcher initiates.

Parameters:
- AW, 13, word-address width of adr_i
- DW, 16, data width; must be a multiple of 8
- DEPTH, 4096, number of DW-bit words implemented; DEPTH <= 2**AW
- WAIT_STATES, 1, extra wait cycles per transfer; legal range 0..15

Ports:
- clk_i  input  1  SYSCON clock
- reset_i  input  1  SYSCON reset, asynchronous, active-low
- cyc_i  input  1  bus cycle in progress
- stb_i  input  1  transfer strobe
- we_i  input  1  1 = write, 0 = read
- adr_i  input  AW  word address
- dat_i  input  DW  write data
- sel_i  input  DW/8  byte-lane enables; bit k covers dat bits 8k+7..8k
- dat_o  output  DW  read data, valid while ack_o = 1
- ack_o  output  1  normal transfer termination
- err_o  output  1  error termination (address >= DEPTH)

Behaviour:
- Reset (reset_i = 0, asynchronous): state = IDLE, cnt = 0, ack_o = 0, err_o = 0, dat_o = 0. RAM contents are not reset. Deassertion is sampled at clk_i rising edges.
- States and transitions:
  - IDLE: on an edge sampling cyc_i & stb_i = 1, capture adr_i, we_i, dat_i, sel_i; set cnt = WAIT_STATES; go to WAIT. Otherwise stay in IDLE.
  - WAIT: if cyc_i = 0 or stb_i = 0 is sampled, abort to IDLE with no ack, no err and no write. Else if cnt = 0, go to RESP; else decrement cnt.
  - RESP: lasts exactly one cycle, then IDLE unconditionally. ack_o and err_o return to 0 on leaving RESP.
- Latency: a request sampled at edge N gives ack_o/err_o high for exactly one cycle, starting after edge N+WAIT_STATES+1. Minimum period per transfer is WAIT_STATES+3 cycles, because RESP is always followed by IDLE.
- The edge entering RESP performs the following (all registered, no combinational path from inputs to outputs):
  - Captured address < DEPTH: ack_o <= 1, err_o <= 0.
    - Write: each RAM byte lane with sel = 1 is updated from the captured dat_i; lanes with sel = 0 are unchanged.
    - Read: dat_o <= RAM[captured adr].
  - Captured address >= DEPTH: err_o <= 1, ack_o <= 0. No RAM write; on a read, dat_o <= 0.
- dat_o holds its last value outside read responses; masters must sample it only while ack_o = 1.
- ack_o and err_o are never high simultaneously.
- Inputs changing during WAIT do not alter the captured transfer; only cyc_i and stb_i are monitored, for abort.
- cyc_i/stb_i dropping during RESP does not cancel the response: the write has already committed and ack_o still pulses.
- A write with sel_i = 0 acks normally and changes nothing.
- Reset asserted mid-transfer: immediate return to IDLE and outputs cleared. No write occurs unless the RESP-entry edge already happened.
- WAIT_STATES = 0: WAIT lasts one cycle (cnt already 0), so ack arrives after edge N+1.

Test Plan:
- Reset then write 0xBEEF to adr 0x010 with sel=2'b11, then read adr 0x010 (WAIT_STATES=1) -> ack_o pulses once per transfer, 3 cycles after request sample; read returns dat_o=0xBEEF.
- Preload 0x1234 at adr 5, then write 0xAB00 with sel=2'b10 -> subsequent read returns 0xAB34.
- Read adr 0x1000 (>= DEPTH=4096) -> err_o pulses one cycle, ack_o stays 0, dat_o=0; write to 0x1FFF leaves RAM unchanged (verify adr 0x0FFF intact).
- Write 0x5555 to adr 7 holding 0x0000, dropping stb_i during WAIT with WAIT_STATES=3 -> no ack/err, FSM returns to IDLE; read of adr 7 returns 0x0000.
- Master holds cyc_i/stb_i high for back-to-back reads of adr 1, 2, 3 -> three acks spaced WAIT_STATES+3 cycles apart with correct data each time.
- Assert reset_i=0 asynchronously between clock edges during WAIT -> ack_o, err_o, dat_o go 0 immediately; no write observed afterward. Rerun first scenario with WAIT_STATES=0 -> ack 2 cycles after request sample.
